scan_chain_loader: RTL and testbench

SCAN_CHAIN_LOADER -- requirements
Module: scan_chain_loader

---
 rtl/scan_chain_loader_if.sv | 36 +++
 rtl/scan_chain_loader.sv | 127 ++++++++++++
 tb/tb_scan_chain_loader.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/scan_chain_loader_if.sv
// Host-side bundle of the scan chain loader: word handshake, start/status and the serial chain drive.
// Signal suffixes are given from the loader's point of view.
interface scan_chain_loader_if #(
    parameter int WORD_W = 32
);
    logic              start_i;
    logic [WORD_W-1:0] in_data_i;
    logic              in_valid_i;
    logic              in_ready_o;
    logic              sin_o;
    logic              ce_o;
    logic              busy_o;
    logic              done_o;

    modport slave (
        input  start_i,
        input  in_data_i,
        input  in_valid_i,
        output in_ready_o,
        output sin_o,
        output ce_o,
        output busy_o,
        output done_o
    );

    modport master (
        output start_i,
        output in_data_i,
        output in_valid_i,
        input  in_ready_o,
        input  sin_o,
        input  ce_o,
        input  busy_o,
        input  done_o
    );
endinterface

// File: rtl/scan_chain_loader.sv
// Serialises host configuration words, LSB first, into a CHAIN_LEN-bit SRL scan chain.
// Prefetches the next word on the last bit of the current one so that back-to-back shifting has no gap.
module scan_chain_loader #(
    parameter int CHAIN_LEN = 512,
    parameter int WORD_W    = 32
) (
    input  logic                clk_i,
    input  logic                rst_i,
    scan_chain_loader_if.slave  bus_io
);
    localparam int CNT_W = $clog2(CHAIN_LEN + 1);
    localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [CNT_W-1:0] CHAIN_LAST = CNT_W'(CHAIN_LEN);
    localparam logic [IDX_W-1:0] WORD_LAST  = IDX_W'(WORD_W - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        SHIFT   = 2'd2,
        DONE_ST = 2'd3
    } state_t;

    state_t            state_q;
    // Bits presented on SIN so far in this sequence, including the one currently on SIN.
    logic [CNT_W-1:0]  bit_cnt_q;
    logic [IDX_W-1:0]  word_idx_q;
    logic [WORD_W-1:0] shreg_q;
    logic              sin_q;
    logic              ce_q;
    logic              in_ready_q;
    logic              busy_q;
    logic              done_q;

    logic              accept_s;
    logic [CNT_W-1:0]  bit_cnt_d;
    logic [IDX_W-1:0]  word_idx_d;

    // A new word may be taken while presenting bit idx only if it is the word's last bit and chain bits remain.
    function automatic logic ready_after(input logic [IDX_W-1:0] idx, input logic [CNT_W-1:0] cnt);
        ready_after = (idx == WORD_LAST) && (cnt < CHAIN_LAST);
    endfunction

    // Handshake qualifier and counter increments.
    always_comb begin
        accept_s   = in_ready_q & bus_io.in_valid_i;
        bit_cnt_d  = bit_cnt_q + CNT_W'(1'b1);
        word_idx_d = word_idx_q + IDX_W'(1'b1);
    end

    // Load sequencer: state, counters, shift register and all registered outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            word_idx_q <= '0;
            shreg_q    <= '0;
            sin_q      <= 1'b0;
            ce_q       <= 1'b0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE_ST: begin
                    if (bus_io.start_i) begin
                        state_q    <= FETCH;
                        bit_cnt_q  <= '0;
                        word_idx_q <= '0;
                        sin_q      <= 1'b0;
                        ce_q       <= 1'b0;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b1;
                        done_q     <= 1'b0;
                    end else begin
                        state_q    <= state_q;
                    end
                end
                FETCH, SHIFT: begin
                    if ((state_q == SHIFT) && (bit_cnt_q == CHAIN_LAST)) begin
                        // Final chain bit just presented; a partial last word ends here too.
                        state_q    <= DONE_ST;
                        sin_q      <= 1'b0;
                        ce_q       <= 1'b0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                    end else if (accept_s) begin
                        state_q    <= SHIFT;
                        shreg_q    <= bus_io.in_data_i >> 1'b1;
                        sin_q      <= bus_io.in_data_i[0];
                        ce_q       <= 1'b1;
                        word_idx_q <= '0;
                        bit_cnt_q  <= bit_cnt_d;
                        in_ready_q <= ready_after(IDX_W'(1'b0), bit_cnt_d);
                    end else if ((state_q == SHIFT) && (word_idx_q != WORD_LAST)) begin
                        shreg_q    <= shreg_q >> 1'b1;
                        sin_q      <= shreg_q[0];
                        ce_q       <= 1'b1;
                        word_idx_q <= word_idx_d;
                        bit_cnt_q  <= bit_cnt_d;
                        in_ready_q <= ready_after(word_idx_d, bit_cnt_d);
                    end else begin
                        // Word exhausted with no new word: stall with the chain frozen.
                        state_q    <= FETCH;
                        sin_q      <= 1'b0;
                        ce_q       <= 1'b0;
                        in_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    sin_q      <= 1'b0;
                    ce_q       <= 1'b0;
                    in_ready_q <= 1'b0;
                    busy_q     <= 1'b0;
                    done_q     <= 1'b0;
                end
            endcase
        end
    end

    assign bus_io.in_ready_o = in_ready_q;
    assign bus_io.sin_o      = sin_q;
    assign bus_io.ce_o       = ce_q;
    assign bus_io.busy_o     = busy_q;
    assign bus_io.done_o     = done_q;
endmodule

// File: tb/tb_scan_chain_loader.sv
// Bench for scan_chain_loader: a 40/16 instance checked cycle by cycle against a queue-based model,
// and a 512/32 instance loading a modelled 16-SRL chain.
module tb_scan_chain_loader;
    localparam int CL  = 40;
    localparam int WW  = 16;
    localparam int CL2 = 512;
    localparam int WW2 = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    scan_chain_loader_if #(.WORD_W(WW))  bus_a ();
    scan_chain_loader_if #(.WORD_W(WW2)) bus_b ();

    scan_chain_loader #(.CHAIN_LEN(CL), .WORD_W(WW)) dut_a (
        .clk_i (clk),
        .rst_i (rst),
        .bus_io(bus_a)
    );

    scan_chain_loader #(.CHAIN_LEN(CL2), .WORD_W(WW2)) dut_b (
        .clk_i (clk),
        .rst_i (rst),
        .bus_io(bus_b)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model of the 40/16 instance ----------------
    int          m_mode = 0;   // 0 idle, 1 waiting for word, 2 shifting, 3 done
    int          m_sent = 0;   // chain bits whose CE cycle has completed
    int          m_acc  = 0;   // words accepted this sequence
    logic        m_bits[$];    // bits of the current word still to be presented
    logic        e_ce = 1'b0, e_sin = 1'b0, e_rdy = 1'b0, e_busy = 1'b0, e_done = 1'b0;
    logic [WW-1:0] words_a [3];

    task automatic m_take(input logic [WW-1:0] d);
        int n;
        n = ((CL - m_sent) < WW) ? (CL - m_sent) : WW;
        for (int i = 0; i < n; i++) m_bits.push_back(d[i]);
        m_acc++;
        m_mode = 2;
        e_sin  = m_bits.pop_front();
        e_ce   = 1'b1;
        e_rdy  = (m_bits.size() == 0) && (m_sent + 1 < CL);
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mode = 0; m_sent = 0; m_bits.delete();
            e_ce = 1'b0; e_sin = 1'b0; e_rdy = 1'b0; e_busy = 1'b0; e_done = 1'b0;
        end else begin
            case (m_mode)
                0, 3: if (bus_a.start_i) begin
                    m_mode = 1; m_sent = 0; m_acc = 0; m_bits.delete();
                    e_done = 1'b0; e_busy = 1'b1; e_rdy = 1'b1; e_ce = 1'b0; e_sin = 1'b0;
                end
                1: if (bus_a.in_valid_i) m_take(bus_a.in_data_i);
                2: begin
                    m_sent++;
                    if (m_sent == CL) begin
                        m_mode = 3; e_done = 1'b1; e_busy = 1'b0; e_rdy = 1'b0; e_ce = 1'b0; e_sin = 1'b0;
                    end else if (m_bits.size() > 0) begin
                        e_sin = m_bits.pop_front();
                        e_ce  = 1'b1;
                        e_rdy = (m_bits.size() == 0) && (m_sent + 1 < CL);
                    end else if (bus_a.in_valid_i) begin
                        m_take(bus_a.in_data_i);
                    end else begin
                        m_mode = 1; e_ce = 1'b0; e_sin = 1'b0; e_rdy = 1'b1;
                    end
                end
                default: m_mode = 0;
            endcase
        end
    end

    // ---------------- per-cycle compare of the 40/16 instance ----------------
    int          ce_cnt    = 0;
    int          stall_cnt = 0;
    logic [CL-1:0] cap     = '0;

    always @(negedge clk) begin
        if (!rst) begin
            check("ce",       bus_a.ce_o,       e_ce);
            check("sin",      bus_a.sin_o,      e_sin);
            check("in_ready", bus_a.in_ready_o, e_rdy);
            check("busy",     bus_a.busy_o,     e_busy);
            check("done",     bus_a.done_o,     e_done);
            if (bus_a.ce_o) begin
                if (ce_cnt < CL) cap[ce_cnt] = bus_a.sin_o;
                ce_cnt++;
            end else if (bus_a.busy_o) begin
                stall_cnt++;
            end
        end
    end

    // ---------------- 512/32 instance: chain scoreboard ----------------
    logic [CL2-1:0] chain    = '0;
    int             ce_cnt_b = 0;
    logic [WW2-1:0] words_b [16];

    always @(negedge clk) begin
        if (!rst && bus_b.ce_o) begin
            chain = {chain[CL2-2:0], bus_b.sin_o};
            ce_cnt_b++;
        end
    end

    function automatic logic [31:0] rev32(input logic [31:0] x);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = x[31 - i];
        return r;
    endfunction

    // Runs one sequence on the 40/16 instance. Edge 0 samples START; returns the edge at which DONE rose.
    task automatic drive_seq(input int gap_lo, input int gap_hi, input int pulse, input int pct,
                             input int abort, output int done_edge);
        bit fin;
        fin       = 1'b0;
        done_edge = -1;
        ce_cnt    = 0;
        stall_cnt = 0;
        cap       = '0;
        bus_a.start_i    = 1'b1;
        bus_a.in_valid_i = 1'b1;
        bus_a.in_data_i  = words_a[0];
        for (int r = 0; r < 400 && !fin; r++) begin
            @(posedge clk); #1;
            if (r == abort) begin
                #2 rst = 1'b1;
                #1;
                check("rst_ce",   bus_a.ce_o,   1'b0);
                check("rst_busy", bus_a.busy_o, 1'b0);
                check("rst_done", bus_a.done_o, 1'b0);
                fin = 1'b1;
            end else if (bus_a.done_o) begin
                done_edge = r;
                fin = 1'b1;
            end else begin
                bus_a.start_i    = (r + 1 == pulse);
                bus_a.in_valid_i = !((r + 1 >= gap_lo) && (r + 1 <= gap_hi)) &&
                                   ($urandom_range(99) < pct);
                bus_a.in_data_i  = (m_acc < 3) ? words_a[m_acc] : WW'($urandom);
            end
        end
        bus_a.start_i = 1'b0;
        if (!fin) check("seq_timeout", 0, 1);
    endtask

    initial begin
        int de;
        int acc_b;
        bit fin_b;
        logic [31:0] sout;

        bus_a.start_i = 1'b0; bus_a.in_valid_i = 1'b0; bus_a.in_data_i = '0;
        bus_b.start_i = 1'b0; bus_b.in_valid_i = 1'b0; bus_b.in_data_i = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_ce",       bus_a.ce_o,       1'b0);
        check("reset_sin",      bus_a.sin_o,      1'b0);
        check("reset_in_ready", bus_a.in_ready_o, 1'b0);
        check("reset_busy",     bus_a.busy_o,     1'b0);
        check("reset_done",     bus_a.done_o,     1'b0);

        // 512-bit chain of 16 SRLs fed with random words and random valid gaps
        for (int i = 0; i < 16; i++) words_b[i] = $urandom;
        @(posedge clk); #1;
        acc_b = 0; fin_b = 1'b0;
        bus_b.start_i = 1'b1; bus_b.in_valid_i = 1'b1; bus_b.in_data_i = words_b[0];
        @(posedge clk); #1 bus_b.start_i = 1'b0;
        for (int r = 0; r < 5000 && !fin_b; r++) begin
            @(negedge clk);
            if (bus_b.in_valid_i && bus_b.in_ready_o) acc_b++;
            @(posedge clk); #1;
            if (bus_b.done_o) fin_b = 1'b1;
            bus_b.in_valid_i = ($urandom_range(99) < 70);
            bus_b.in_data_i  = (acc_b < 16) ? words_b[acc_b] : $urandom;
        end
        bus_b.in_valid_i = 1'b0;
        check("b_done",     fin_b,    1);
        check("b_ce_count", ce_cnt_b, CL2);
        for (int j = 0; j < 16; j++)
            check($sformatf("srl%0d", j), chain[32*j +: 32], rev32(words_b[15 - j]));
        for (int n = 0; n < 32; n++) sout[n] = chain[CL2 - 1 - n];
        check("sout_word0", sout, words_b[0]);

        // baseline 3-word load, valid always high
        words_a[0] = 16'hA5C3; words_a[1] = 16'h0FF0; words_a[2] = 16'h12FF;
        drive_seq(0, -1, -1, 100, -1, de);
        check("base_done_edge", de, 41);
        check("base_ce_count",  ce_cnt, 40);
        check("base_stall",     stall_cnt, 1);
        check("base_bits",      cap, 40'hFF0FF0A5C3);

        // valid withheld for 5 cycles after the first word
        drive_seq(17, 21, -1, 100, -1, de);
        check("gap_done_edge", de, 46);
        check("gap_ce_count",  ce_cnt, 40);
        check("gap_stall",     stall_cnt, 6);
        check("gap_bits",      cap, 40'hFF0FF0A5C3);

        // START pulsed during bit 10 of the second word
        drive_seq(0, -1, 28, 100, -1, de);
        check("pulse_done_edge", de, 41);
        check("pulse_bits",      cap, 40'hFF0FF0A5C3);

        // reset during bit 20, then a clean reload
        drive_seq(0, -1, -1, 100, 21, de);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("post_rst_done", bus_a.done_o, 1'b0);
        drive_seq(0, -1, -1, 100, -1, de);
        check("reload_done_edge", de, 41);
        check("reload_ce_count",  ce_cnt, 40);
        check("reload_bits",      cap, 40'hFF0FF0A5C3);

        // valid held after DONE must be ignored
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            bus_a.in_valid_i = 1'b1;
            bus_a.in_data_i  = WW'($urandom);
            @(negedge clk);
            check("done_in_ready", bus_a.in_ready_o, 1'b0);
            check("done_ce",       bus_a.ce_o,       1'b0);
            check("done_hold",     bus_a.done_o,     1'b1);
        end
        @(posedge clk); #1;

        // randomized sequences: random words, valid density and stray START pulses
        for (int s = 0; s < 6; s++) begin
            for (int i = 0; i < 3; i++) words_a[i] = WW'($urandom);
            drive_seq(0, -1, $urandom_range(60, 1), $urandom_range(100, 40), -1, de);
            check("rnd_ce_count", ce_cnt, 40);
            check("rnd_bits", cap, {words_a[2][7:0], words_a[1], words_a[0]});
            repeat ($urandom_range(3, 0)) @(posedge clk);
            #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
